// File: rtl/nim_pkg.sv
// Shared Nim game types and constants: press-arbitration priority token
// and the system-clock-derived default debounce window.
package nim_pkg;

  typedef enum logic {PRI_LEFT = 1'b0, PRI_RIGHT = 1'b1} pri_t;

  localparam int NIM_CLK_HZ              = 100_000_000;
  localparam int NIM_DEBOUNCE_CYCLES     = NIM_CLK_HZ / 100;
  localparam int NIM_SYNC_STAGES_DEFAULT = 2;

  function automatic pri_t pri_toggle(input pri_t cur);
    pri_t nxt;
    case (cur)
      PRI_LEFT:  nxt = PRI_RIGHT;
      PRI_RIGHT: nxt = PRI_LEFT;
      default:   nxt = PRI_LEFT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: metastability synchronizer, saturating stability
// counter and debounced level register with a rising-level press strobe.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic lvl,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_chain_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic                   lvl_r;
  logic                   lvl_s;
  logic                   press_s;

  // Synchronizer chain; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_chain_r <= '0;
    end else begin
      sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], btn};
    end
  end

  assign sync_s = sync_chain_r[SYNC_STAGES-1];

  // Level flips only after the synchronized input disagrees for the full window.
  always_comb begin
    cnt_s   = cnt_r;
    lvl_s   = lvl_r;
    press_s = 1'b0;
    if (sync_s != lvl_r) begin
      if (cnt_r >= CNT_LAST) begin
        lvl_s   = ~lvl_r;
        cnt_s   = '0;
        press_s = ~lvl_r;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = '0;
    end
  end

  // Counter and debounced level state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
      lvl_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      lvl_r <= lvl_s;
    end
  end

  assign lvl   = lvl_r;
  assign press = press_s;

endmodule

// File: rtl/player_input_conditioner.sv
// Conditions both player buttons into clean one-cycle press pulses and
// serialises simultaneous presses using an alternating priority token.
module player_input_conditioner
  import nim_pkg::*;
#(
  parameter int SYNC_STAGES     = NIM_SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = NIM_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_l,
  input  logic i_btn_r,
  output logic o_ilp,
  output logic o_irp,
  output logic o_lvl_l,
  output logic o_lvl_r,
  output logic o_conflict
);

  logic press_l_s;
  logic press_r_s;
  logic lvl_l_s;
  logic lvl_r_s;

  pri_t token_r;
  pri_t token_s;
  logic pending_r;
  logic pending_s;
  logic ilp_r;
  logic ilp_s;
  logic irp_r;
  logic irp_s;
  logic conflict_r;
  logic conflict_s;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_l (
    .clk   (clk),
    .rst   (rst),
    .btn   (i_btn_l),
    .lvl   (lvl_l_s),
    .press (press_l_s)
  );

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_r (
    .clk   (clk),
    .rst   (rst),
    .btn   (i_btn_r),
    .lvl   (lvl_r_s),
    .press (press_r_s)
  );

  // Arbitration: the deferred pulse belongs to the player now holding the
  // token, because the token flips in the same cycle the deferral is made.
  always_comb begin
    ilp_s      = 1'b0;
    irp_s      = 1'b0;
    conflict_s = 1'b0;
    pending_s  = 1'b0;
    token_s    = token_r;
    if (pending_r) begin
      if (token_r == PRI_LEFT) begin
        ilp_s = 1'b1;
      end else begin
        irp_s = 1'b1;
      end
    end else if (press_l_s && press_r_s) begin
      conflict_s = 1'b1;
      pending_s  = 1'b1;
      token_s    = pri_toggle(token_r);
      if (token_r == PRI_LEFT) begin
        ilp_s = 1'b1;
      end else begin
        irp_s = 1'b1;
      end
    end else if (press_l_s) begin
      ilp_s = 1'b1;
    end else if (press_r_s) begin
      irp_s = 1'b1;
    end else begin
      ilp_s = 1'b0;
    end
  end

  // Arbitration state and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token_r    <= PRI_LEFT;
      pending_r  <= 1'b0;
      ilp_r      <= 1'b0;
      irp_r      <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      token_r    <= token_s;
      pending_r  <= pending_s;
      ilp_r      <= ilp_s;
      irp_r      <= irp_s;
      conflict_r <= conflict_s;
    end
  end

  assign o_ilp      = ilp_r;
  assign o_irp      = irp_r;
  assign o_conflict = conflict_r;
  assign o_lvl_l    = lvl_l_s;
  assign o_lvl_r    = lvl_r_s;

endmodule
